// File: rtl/amm_resp_pkg.sv
// ---------------------------------------------------------------------------
// amm_resp_pkg
// Shared types and constants for the Avalon-MM response/push buffer.
//   state_e        : control FSM states (IDLE, RD_RESP, CLEAR)
//   ADDR_STATUS    : 0x00, status word / soft clear
//   ADDR_SCRATCH   : 0x08, general purpose read/write register
//   ADDR_LEVEL     : 0x0C, free space in the push buffer
//   ADDR_DATA_BASE : 0x10, start of the data push window
// ---------------------------------------------------------------------------
package amm_resp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_RESP,
        CLEAR
    } state_e;

    localparam logic [31:0] ADDR_STATUS    = 32'h0000_0000;
    localparam logic [31:0] ADDR_SCRATCH   = 32'h0000_0008;
    localparam logic [31:0] ADDR_LEVEL     = 32'h0000_000C;
    localparam logic [31:0] ADDR_DATA_BASE = 32'h0000_0010;

endpackage

// File: rtl/amm_resp_fifo.sv
// ---------------------------------------------------------------------------
// amm_resp_fifo
// Storage and pointer logic for the push buffer (32-bit words).
// Ports:
//   clk, n_rst     : clock, asynchronous active-low reset
//   clear_i        : synchronous flush of pointers and count
//   push_i         : write pushData_i at the tail (ignored when full)
//   pop_i          : drop the head word (ignored when empty)
//   pushData_i     : word to push
//   headData_o     : current head word, read combinationally
//   full_o, empty_o: occupancy flags
//   count_o        : number of stored words, 0..DEPTH
// ---------------------------------------------------------------------------
module amm_resp_fifo #(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [31:0]      pushData_i,
    output logic [31:0]      headData_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             doPush;
    logic             doPop;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign doPush     = push_i && !full_o && !clear_i;
    assign doPop      = pop_i && !empty_o && !clear_i;
    assign headData_o = mem[rdPtr_q];
    assign count_o    = count_q;

    // Next-state pointers and count. DEPTH is a power of two, so the
    // pointers wrap on their own; a simultaneous push and pop cancels out.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (clear_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (doPush) wrPtr_d = wrPtr_q + PTR_W'(1);
            if (doPop)  rdPtr_d = rdPtr_q + PTR_W'(1);
            if (doPush && !doPop)      count_d = count_q + CNT_W'(1);
            else if (doPop && !doPush) count_d = count_q - CNT_W'(1);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Word storage has no reset; only entries below the count are ever observed.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr_q] <= pushData_i;
    end

endmodule

// File: rtl/amm_resp_buffer.sv
// ---------------------------------------------------------------------------
// amm_resp_buffer
// Avalon-MM slave with a small register map and a push buffer drained by a
// local consumer.
// Ports:
//   clk, n_rst                 : clock, asynchronous active-low reset
//   address, read, write,
//   writedata                  : Avalon-MM request side
//   waitrequest, readdata,
//   readdatavalid              : Avalon-MM response side (1-cycle read latency)
//   drain_data, drain_valid,
//   drain_ready                : head-of-buffer consumer handshake
//   err                        : sticky error (read/write collision, bad address)
// Optional feature: define AMM_RESP_ADDR_CHECK_EN to require DATA writes to
// arrive at consecutive word addresses starting from 0x10.
// ---------------------------------------------------------------------------
module amm_resp_buffer
    import amm_resp_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        readdatavalid,
    output logic [31:0] drain_data,
    output logic        drain_valid,
    input  logic        drain_ready,
    output logic        err
);

    state_e           state_q;
    logic [31:0]      scratch_q;
    logic [31:0]      readData_q;
    logic             readDataValid_q;
    logic             err_q;

    logic             fifoFull;
    logic             fifoEmpty;
    logic [CNT_W-1:0] fifoCount;
    logic [CNT_W-1:0] freeSpace;
    logic [31:0]      regReadValue;

    logic             isIdle;
    logic             isData;
    logic             dataStall;
    logic             rdAccept;
    logic             wrAccept;
    logic             addrOk;
    logic             dataPush;
    logic             softClear;

`ifdef AMM_RESP_ADDR_CHECK_EN
    logic [31:0]      expAddr_q;
    assign addrOk = (address == expAddr_q);
`else
    assign addrOk = 1'b1;
`endif

    // Request qualification. A read always wins in IDLE; a concurrent write
    // is simply not taken. Only a DATA write into a full buffer is stalled.
    assign isIdle    = (state_q == IDLE);
    assign isData    = (address >= ADDR_DATA_BASE);
    assign dataStall = write && !read && isData && fifoFull;
    assign rdAccept  = isIdle && read;
    assign wrAccept  = isIdle && write && !read && !(isData && fifoFull);
    assign dataPush  = wrAccept && isData && addrOk;
    assign softClear = wrAccept && (address == ADDR_STATUS) && writedata[0];
    assign freeSpace = CNT_W'(DEPTH) - fifoCount;

    assign waitrequest   = !isIdle || dataStall;
    assign readdata      = readData_q;
    assign readdatavalid = readDataValid_q;
    assign drain_valid   = !fifoEmpty;
    assign err           = err_q;

    // Register read mux, captured into readData_q when a read is accepted.
    always_comb begin
        regReadValue = '0;
        if (address == ADDR_STATUS)
            regReadValue = {err_q, 15'b0, 16'(fifoCount)};
        else if (address == ADDR_SCRATCH)
            regReadValue = scratch_q;
        else if (address == ADDR_LEVEL)
            regReadValue = 32'(freeSpace);
    end

    amm_resp_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .n_rst      (n_rst),
        .clear_i    (state_q == CLEAR),
        .push_i     (dataPush),
        .pop_i      (drain_ready),
        .pushData_i (writedata),
        .headData_o (drain_data),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty),
        .count_o    (fifoCount)
    );

    // Control FSM with registered read response, scratch and error flag.
    // RD_RESP and CLEAR each last exactly one cycle and hold waitrequest.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q         <= IDLE;
            scratch_q       <= '0;
            readData_q      <= '0;
            readDataValid_q <= 1'b0;
            err_q           <= 1'b0;
`ifdef AMM_RESP_ADDR_CHECK_EN
            expAddr_q       <= ADDR_DATA_BASE;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (rdAccept) begin
                        readData_q      <= regReadValue;
                        readDataValid_q <= 1'b1;
                        state_q         <= RD_RESP;
                        if (write) err_q <= 1'b1;
                    end else if (wrAccept) begin
                        if (address == ADDR_SCRATCH) scratch_q <= writedata;
                        if (softClear) state_q <= CLEAR;
`ifdef AMM_RESP_ADDR_CHECK_EN
                        if (isData && !addrOk) err_q <= 1'b1;
                        if (dataPush) expAddr_q <= expAddr_q + 32'd4;
`endif
                    end
                end
                RD_RESP: begin
                    readDataValid_q <= 1'b0;
                    readData_q      <= '0;
                    state_q         <= IDLE;
                end
                CLEAR: begin
                    err_q   <= 1'b0;
`ifdef AMM_RESP_ADDR_CHECK_EN
                    expAddr_q <= ADDR_DATA_BASE;
`endif
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
